// File: rtl/wb_uart_master_if.sv
// Signal bundle between the UART-driven Wishbone master and its environment:
// the rx/tx byte streams, the Wishbone master bus and the busy flag.
interface wb_uart_master_if;
  logic [7:0]  rx_byte_i;
  logic        rx_valid_i;
  logic [7:0]  tx_byte_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stall_i;
  logic        wb_ack_i;
  logic [31:0] wb_dat_i;
  logic        wb_err_i;
  logic        busy_o;

  modport master (
    input  rx_byte_i, rx_valid_i, tx_ready_i,
           wb_stall_i, wb_ack_i, wb_dat_i, wb_err_i,
    output tx_byte_o, tx_valid_o,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
           busy_o
  );

  modport slave (
    output rx_byte_i, rx_valid_i, tx_ready_i,
           wb_stall_i, wb_ack_i, wb_dat_i, wb_err_i,
    input  tx_byte_o, tx_valid_o,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
           busy_o
  );
endinterface

// File: rtl/wb_uart_master.sv
// UART byte-stream to Wishbone pipelined master bridge: parses W/R frames,
// issues one 32-bit single-beat access and returns a status/data frame.
module wb_uart_master #(
  parameter int unsigned TIMEOUT = 1024,
  parameter logic [7:0]  CMD_WR  = 8'h57,
  parameter logic [7:0]  CMD_RD  = 8'h52
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  wb_uart_master_if.master bus
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [7:0]  ST_OK    = 8'h4B;
  localparam logic [7:0]  ST_ERR   = 8'h45;
  localparam logic [7:0]  ST_TMO   = 8'h54;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS_REQ,
    S_BUS_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_we;
  logic [1:0]  r_byte_cnt;
  logic [31:0] r_adr;
  logic [31:0] r_wdat;
  logic [31:0] r_rdat;
  logic [7:0]  r_tx_byte;
  logic [2:0]  r_tx_left;
  logic [15:0] r_tmo;

  logic        w_rx_cmd;
  logic        w_tmo_hit;
  logic        w_done_ok;
  logic        w_done_err;
  logic        w_done_tmo;

  assign w_rx_cmd  = bus.rx_valid_i &&
                     ((bus.rx_byte_i == CMD_WR) || (bus.rx_byte_i == CMD_RD));
  assign w_tmo_hit = (r_tmo == TMO_LAST);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Completion priority: err over ack, ack over timeout. In BUS_REQ the
  // slave response only counts on the acceptance (stall low) edge.
  always_comb begin
    w_next     = r_state;
    w_done_ok  = 1'b0;
    w_done_err = 1'b0;
    w_done_tmo = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rx_cmd) w_next = S_ADDR;
      end
      S_ADDR: begin
        if (bus.rx_valid_i && (r_byte_cnt == 2'd3))
          w_next = r_we ? S_DATA : S_BUS_REQ;
      end
      S_DATA: begin
        if (bus.rx_valid_i && (r_byte_cnt == 2'd3)) w_next = S_BUS_REQ;
      end
      S_BUS_REQ: begin
        if (!bus.wb_stall_i) begin
          if (bus.wb_err_i)      w_done_err = 1'b1;
          else if (bus.wb_ack_i) w_done_ok  = 1'b1;
          else if (w_tmo_hit)    w_done_tmo = 1'b1;
          else                   w_next     = S_BUS_WAIT;
        end else if (w_tmo_hit) begin
          w_done_tmo = 1'b1;
        end
      end
      S_BUS_WAIT: begin
        if (bus.wb_err_i)      w_done_err = 1'b1;
        else if (bus.wb_ack_i) w_done_ok  = 1'b1;
        else if (w_tmo_hit)    w_done_tmo = 1'b1;
      end
      S_RESP: begin
        if (bus.tx_ready_i && (r_tx_left == 3'd0)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_done_ok || w_done_err || w_done_tmo) w_next = S_RESP;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_we       <= 1'b0;
      r_byte_cnt <= '0;
      r_adr      <= '0;
      r_wdat     <= '0;
      r_rdat     <= '0;
      r_tx_byte  <= '0;
      r_tx_left  <= '0;
      r_tmo      <= '0;
    end else begin
      r_tmo <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_rx_cmd) begin
            r_we       <= (bus.rx_byte_i == CMD_WR);
            r_byte_cnt <= '0;
          end
        end
        S_ADDR: begin
          if (bus.rx_valid_i) begin
            r_adr      <= {r_adr[23:0], bus.rx_byte_i};
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        S_DATA: begin
          if (bus.rx_valid_i) begin
            r_wdat     <= {r_wdat[23:0], bus.rx_byte_i};
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        S_BUS_REQ, S_BUS_WAIT: begin
          r_tmo <= r_tmo + 16'd1;
          if (w_done_err) begin
            r_tx_byte <= ST_ERR;
            r_tx_left <= '0;
          end else if (w_done_ok) begin
            r_tx_byte <= ST_OK;
            if (!r_we) begin
              r_rdat    <= bus.wb_dat_i;
              r_tx_left <= 3'd4;
            end else begin
              r_tx_left <= '0;
            end
          end else if (w_done_tmo) begin
            r_tx_byte <= ST_TMO;
            r_tx_left <= '0;
          end
        end
        S_RESP: begin
          // Read data streams out of r_rdat MSB first after the status byte.
          if (bus.tx_ready_i) begin
            if (r_tx_left != 3'd0) begin
              r_tx_byte <= r_rdat[31:24];
              r_rdat    <= {r_rdat[23:0], 8'h00};
              r_tx_left <= r_tx_left - 3'd1;
            end else begin
              r_tx_byte <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.wb_cyc_o   = (r_state == S_BUS_REQ) || (r_state == S_BUS_WAIT);
  assign bus.wb_stb_o   = (r_state == S_BUS_REQ);
  assign bus.wb_we_o    = bus.wb_cyc_o && r_we;
  assign bus.wb_sel_o   = bus.wb_cyc_o ? 4'hF : 4'h0;
  assign bus.wb_adr_o   = r_adr;
  assign bus.wb_dat_o   = r_wdat;
  assign bus.tx_valid_o = (r_state == S_RESP);
  assign bus.tx_byte_o  = r_tx_byte;
  assign bus.busy_o     = (r_state != S_IDLE);

endmodule

// File: tb/tb_wb_uart_master.sv
// Directed bench for wb_uart_master: a table of frames with expected tx
// responses, plus hand sequences for reset-in-flight and stray-ack cases.
module tb_wb_uart_master;

  logic clk;
  logic rst;
  int unsigned n_checks;
  int unsigned n_err;

  wb_uart_master_if u_if ();

  wb_uart_master #(
    .TIMEOUT(16),
    .CMD_WR (8'h57),
    .CMD_RD (8'h52)
  ) u_dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 ack, 1 err, 2 ack+err together, 3 no response (timeout)
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    int unsigned stall;
    int unsigned kind;
    logic        ack_at_accept;
    logic [31:0] rdat;
    logic        ready_toggle;
    logic        garbage;
    int unsigned exp_n;
    logic [39:0] exp_tx;
  } vec_t;

  vec_t vecs[7];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    u_if.rx_byte_i  = b;
    u_if.rx_valid_i = 1'b1;
    tick;
    u_if.rx_valid_i = 1'b0;
  endtask

  task automatic send_frame(input logic we, input logic [31:0] adr, input logic [31:0] wdat);
    logic [31:0] a;
    logic [31:0] d;
    a = adr;
    d = wdat;
    send_byte(we ? 8'h57 : 8'h52);
    for (int i = 0; i < 4; i++) send_byte(a[31-8*i -: 8]);
    if (we) for (int i = 0; i < 4; i++) send_byte(d[31-8*i -: 8]);
  endtask

  task automatic run_txn(input vec_t v);
    int unsigned stb_cnt;
    int unsigned cyc_cnt;
    int unsigned got;
    int unsigned k;
    logic        pend;
    logic [7:0]  pbyte;
    logic [7:0]  gb[5];
    logic [39:0] e;
    e = v.exp_tx;

    if (v.garbage) begin
      send_byte(8'h00);
      check("garbage00_idle", u_if.busy_o, 1'b0);
      send_byte(8'hFF);
      check("garbageFF_idle", u_if.busy_o, 1'b0);
    end

    send_frame(v.we, v.adr, v.wdat);
    check("req_cyc", u_if.wb_cyc_o, 1'b1);
    check("req_stb", u_if.wb_stb_o, 1'b1);
    check("req_we", u_if.wb_we_o, v.we);
    check("req_sel", u_if.wb_sel_o, 4'hF);
    check("req_adr", u_if.wb_adr_o, v.adr);
    if (v.we) check("req_dat", u_if.wb_dat_o, v.wdat);

    if (v.kind == 3) begin
      cyc_cnt = 0;
      for (int i = 0; i < 100 && u_if.wb_cyc_o; i++) begin
        cyc_cnt++;
        tick;
      end
      check("tmo_cycles", cyc_cnt, 16);
      check("tmo_stb", u_if.wb_stb_o, 1'b0);
    end else begin
      stb_cnt = 1;
      u_if.wb_stall_i = (v.stall != 0);
      for (int i = 0; i < int'(v.stall); i++) begin
        tick;
        if (u_if.wb_stb_o) stb_cnt++;
        check("stall_adr_hold", u_if.wb_adr_o, v.adr);
      end
      check("stb_cycles", stb_cnt, v.stall + 1);
      u_if.wb_stall_i = 1'b0;
      if (v.ack_at_accept) begin
        u_if.wb_ack_i = 1'b1;
        u_if.wb_dat_i = v.rdat;
      end
      tick;
      u_if.wb_ack_i = 1'b0;
      if (!v.ack_at_accept) begin
        check("wait_stb", u_if.wb_stb_o, 1'b0);
        check("wait_cyc", u_if.wb_cyc_o, 1'b1);
        u_if.wb_ack_i = (v.kind != 1);
        u_if.wb_err_i = (v.kind != 0);
        u_if.wb_dat_i = v.rdat;
        tick;
        u_if.wb_ack_i = 1'b0;
        u_if.wb_err_i = 1'b0;
      end
      check("done_cyc", u_if.wb_cyc_o, 1'b0);
    end
    u_if.wb_dat_i = '0;

    check("resp_valid", u_if.tx_valid_o, 1'b1);
    check("resp_status", u_if.tx_byte_o, e[39:32]);

    got  = 0;
    k    = 0;
    pend = 1'b0;
    pbyte = '0;
    while (got < v.exp_n && k < 60) begin
      u_if.tx_ready_i = v.ready_toggle ? ((k % 2) == 1) : 1'b1;
      if (u_if.tx_valid_o) begin
        if (pend) check("tx_hold", u_if.tx_byte_o, pbyte);
        if (u_if.tx_ready_i) begin
          gb[got] = u_if.tx_byte_o;
          got++;
          pend = 1'b0;
        end else begin
          pend  = 1'b1;
          pbyte = u_if.tx_byte_o;
        end
      end else begin
        pend = 1'b0;
      end
      tick;
      k++;
    end
    u_if.tx_ready_i = 1'b0;
    check("tx_count", got, v.exp_n);
    for (int i = 0; i < int'(got); i++) check("tx_byte", gb[i], e[39-8*i -: 8]);
    check("end_tx_valid", u_if.tx_valid_o, 1'b0);
    check("end_busy", u_if.busy_o, 1'b0);

    if (v.kind == 3) begin
      u_if.wb_ack_i = 1'b1;
      tick;
      u_if.wb_ack_i = 1'b0;
      check("stray_busy", u_if.busy_o, 1'b0);
      check("stray_tx", u_if.tx_valid_o, 1'b0);
      tick;
      check("stray_cyc", u_if.wb_cyc_o, 1'b0);
      check("stray_busy2", u_if.busy_o, 1'b0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    vecs[0] = '{we:1'b1, adr:32'h00008014, wdat:32'hDEADBEEF, stall:0, kind:0, ack_at_accept:1'b0,
                rdat:32'h0, ready_toggle:1'b0, garbage:1'b0, exp_n:1, exp_tx:40'h4B00000000};
    vecs[1] = '{we:1'b0, adr:32'h00000100, wdat:32'h0, stall:3, kind:0, ack_at_accept:1'b0,
                rdat:32'h12345678, ready_toggle:1'b1, garbage:1'b0, exp_n:5, exp_tx:40'h4B12345678};
    vecs[2] = '{we:1'b0, adr:32'h00000004, wdat:32'h0, stall:0, kind:1, ack_at_accept:1'b0,
                rdat:32'h0, ready_toggle:1'b0, garbage:1'b1, exp_n:1, exp_tx:40'h4500000000};
    vecs[3] = '{we:1'b0, adr:32'h00000010, wdat:32'h0, stall:0, kind:3, ack_at_accept:1'b0,
                rdat:32'h0, ready_toggle:1'b0, garbage:1'b0, exp_n:1, exp_tx:40'h5400000000};
    vecs[4] = '{we:1'b1, adr:32'h0000000C, wdat:32'h55AA00FF, stall:0, kind:2, ack_at_accept:1'b0,
                rdat:32'h0, ready_toggle:1'b0, garbage:1'b0, exp_n:1, exp_tx:40'h4500000000};
    vecs[5] = '{we:1'b0, adr:32'h00000020, wdat:32'h0, stall:1, kind:0, ack_at_accept:1'b1,
                rdat:32'hA5A50F0F, ready_toggle:1'b1, garbage:1'b0, exp_n:5, exp_tx:40'h4BA5A50F0F};
    vecs[6] = '{we:1'b1, adr:32'h00000100, wdat:32'h01020304, stall:2, kind:1, ack_at_accept:1'b0,
                rdat:32'h0, ready_toggle:1'b0, garbage:1'b0, exp_n:1, exp_tx:40'h4500000000};

    rst             = 1'b1;
    u_if.rx_byte_i  = '0;
    u_if.rx_valid_i = 1'b0;
    u_if.tx_ready_i = 1'b0;
    u_if.wb_stall_i = 1'b0;
    u_if.wb_ack_i   = 1'b0;
    u_if.wb_dat_i   = '0;
    u_if.wb_err_i   = 1'b0;
    #1;
    check("rst_cyc", u_if.wb_cyc_o, 1'b0);
    check("rst_stb", u_if.wb_stb_o, 1'b0);
    check("rst_we", u_if.wb_we_o, 1'b0);
    check("rst_sel", u_if.wb_sel_o, 4'h0);
    check("rst_adr", u_if.wb_adr_o, 32'h0);
    check("rst_dat", u_if.wb_dat_o, 32'h0);
    check("rst_txv", u_if.tx_valid_o, 1'b0);
    check("rst_txb", u_if.tx_byte_o, 8'h0);
    check("rst_busy", u_if.busy_o, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick;

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // Reset asserted while the read sits in BUS_WAIT.
    send_frame(1'b0, 32'h00000040, 32'h0);
    tick;
    check("pre_rst_cyc", u_if.wb_cyc_o, 1'b1);
    check("pre_rst_stb", u_if.wb_stb_o, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_cyc", u_if.wb_cyc_o, 1'b0);
    check("midrst_stb", u_if.wb_stb_o, 1'b0);
    check("midrst_txv", u_if.tx_valid_o, 1'b0);
    check("midrst_busy", u_if.busy_o, 1'b0);
    check("midrst_adr", u_if.wb_adr_o, 32'h0);
    #2;
    rst = 1'b0;
    tick;
    check("postrst_txv", u_if.tx_valid_o, 1'b0);
    run_txn(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/wb_uart_master.md
Name: wb_uart_master

Overview:
- Wishbone pipelined bus master driven by a UART byte stream; a debug/host bridge that is the initiating end of the SoC slave bus.
- Parses command frames from rx bytes, issues one 32-bit single-beat read or write, and returns a status/data frame on a tx byte stream.
- Sits beside core_wb as a second master, arbitrated externally; byte side connects to uart_wb rx/tx.

Parameters:
- TIMEOUT, 1024, cycles allowed from first stb assertion to ack/err before the cycle is abandoned; legal range 2 to 65535.
- CMD_WR, 8'h57, command byte for write ('W').
- CMD_RD, 8'h52, command byte for read ('R').

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  asynchronous active-high reset
- rx_byte_i  in  8  received byte
- rx_valid_i  in  1  one-cycle strobe: rx_byte_i valid
- tx_byte_o  out  8  byte to transmit
- tx_valid_o  out  1  tx_byte_o valid; held until accepted
- tx_ready_i  in  1  transmitter accepts byte when high with tx_valid_o
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  write enable
- wb_adr_o  out  32  byte address
- wb_dat_o  out  32  write data
- wb_sel_o  out  4  byte select, always 4'hF during a cycle
- wb_stall_i  in  1  slave stall
- wb_ack_i  in  1  slave ack
- wb_dat_i  in  32  read data
- wb_err_i  in  1  slave error
- busy_o  out  1  high in every state except IDLE

Behaviour:
- Reset (async, wb_rst_i high): state IDLE; wb_cyc_o, wb_stb_o, wb_we_o, tx_valid_o, busy_o = 0; wb_adr_o, wb_dat_o, tx_byte_o = 0; wb_sel_o = 4'h0; byte counter and timeout counter = 0. Reset mid-operation aborts any bus cycle immediately; no response is sent.
- Frame format, all multi-byte fields MSB first:
  - write: CMD_WR, A3 A2 A1 A0, D3 D2 D1 D0.
  - read: CMD_RD, A3 A2 A1 A0.
- IDLE: on rx_valid_i with CMD_WR or CMD_RD, latch the direction, go to ADDR, and clear the byte counter. Any other byte is dropped silently; stay in IDLE.
- ADDR: each rx_valid_i shifts one byte into the address register. After the 4th byte:
  - write goes to DATA;
  - read goes to BUS_REQ.
- DATA: the same scheme for the 4 data bytes; after the 4th byte, go to BUS_REQ.
- BUS_REQ:
  - Asserted from the cycle after the last frame byte: wb_cyc_o=1, wb_stb_o=1, wb_we_o = direction, wb_sel_o=4'hF, and stable address/data.
  - The timeout counter starts at 0 on entry.
  - While wb_stall_i=1, hold all signals.
  - On the first edge with wb_stall_i=0, the request is accepted: drop wb_stb_o and go to BUS_WAIT.
  - An ack/err sampled on that same acceptance edge completes the cycle directly, as in BUS_WAIT.
- BUS_WAIT: wb_cyc_o=1, wb_stb_o=0.
  - wb_ack_i: capture wb_dat_i when reading, drop wb_cyc_o, and load status 'K' (8'h4B).
  - wb_err_i: drop wb_cyc_o and load status 'E' (8'h45). err wins if ack and err arrive together.
  - Go to RESP.
- Timeout:
  - The counter increments every cycle in BUS_REQ and BUS_WAIT.
  - When it reaches TIMEOUT-1 with no ack/err, drop cyc and stb and load status 'T' (8'h54). An ack on that same edge takes priority over the timeout.
  - Any ack or err arriving after that edge is ignored.
- RESP:
  - Byte 0 is the status byte; for a read with status 'K', bytes 1 to 4 are the read data MSB first. Writes, 'E' and 'T' send the status byte only.
  - tx_valid_o=1 with tx_byte_o stable; a byte transfers on an edge where tx_valid_o and tx_ready_i are both 1. The next byte, if any, is presented on the following cycle.
  - After the last transfer, tx_valid_o=0 and the state returns to IDLE.
- rx_valid_i in BUS_REQ, BUS_WAIT or RESP: byte dropped. The host must await the response before sending the next frame.
- Latency: with zero stall and ack one cycle after acceptance, the status byte is valid 3 cycles after the last rx strobe.
- No inter-byte timeout: a partial frame waits indefinitely until reset.

Test Plan:
- Write: rx 57 00 00 80 14 DE AD BE EF, slave acks 1 cycle after accept -> one cycle with adr=32'h00008014, dat=32'hDEADBEEF, we=1, sel=F; tx 4B only; busy_o low afterwards.
- Read with stall: rx 52 00 00 01 00, stall held 3 cycles, then ack with dat_i=32'h12345678 -> stb high 4 cycles; tx 4B 12 34 56 78, with tx_ready_i toggling 1/0 and each byte held until accepted.
- Error and garbage: rx 00 FF 52 00 00 00 04, slave asserts err -> leading bytes 00 and FF ignored, read issued at 32'h4, tx 45 only.
- Timeout: TIMEOUT=16, no ack -> cyc drops on the 16th cycle after entry to BUS_REQ; tx 54; a later stray ack is ignored and state stays IDLE.
- Ack and err in the same cycle -> tx 45.
- Reset mid-cycle: assert wb_rst_i while in BUS_WAIT -> cyc, stb and tx_valid_o are 0 immediately; a following full frame executes normally.
